dmem_lsu: RTL and testbench

// - Load/store unit: initiator side of the DMEM port. Turns byte/half/word requests from the

---
 rtl/dmem_lsu_if.sv | 33 +++
 rtl/dmem_lsu.sv | 150 +++++++++++++++
 tb/tb_dmem_lsu.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the datapath, the load/store unit and DMEM.
// The LSU connects through the slave modport; the environment uses master.
interface dmem_lsu_if #(
  parameter int ADDR_W = 8
);
  logic              LSU_req;
  logic              LSU_we;
  logic [1:0]        LSU_size;
  logic              LSU_unsigned;
  logic [31:0]       LSU_addr;
  logic [31:0]       LSU_wdata;
  logic              LSU_busy;
  logic              LSU_done;
  logic [31:0]       LSU_rdata;
  logic              LSU_misaligned;
  logic [ADDR_W-1:0] DMEM_address;
  logic [31:0]       DMEM_data_in;
  logic              DMEM_mem_write;
  logic              DMEM_mem_read;
  logic [31:0]       DMEM_data_out;

  modport slave (
    input  LSU_req, LSU_we, LSU_size, LSU_unsigned, LSU_addr, LSU_wdata, DMEM_data_out,
    output LSU_busy, LSU_done, LSU_rdata, LSU_misaligned,
    output DMEM_address, DMEM_data_in, DMEM_mem_write, DMEM_mem_read
  );

  modport master (
    output LSU_req, LSU_we, LSU_size, LSU_unsigned, LSU_addr, LSU_wdata, DMEM_data_out,
    input  LSU_busy, LSU_done, LSU_rdata, LSU_misaligned,
    input  DMEM_address, DMEM_data_in, DMEM_mem_write, DMEM_mem_read
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit driving a 32-bit DMEM with 1-cycle registered read; sub-word stores use RMW.
// Optional macro LSU_MISALIGN_CHECK_EN aborts misaligned half/word accesses instead of aligning down.
module dmem_lsu #(
  parameter int ADDR_W = 8
) (
  input  logic       LSU_clk,
  input  logic       LSU_rst,
  dmem_lsu_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, RMW_RD, RMW_WAIT, RMW_WR, WR} state_t;

  state_t            state_q, state_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_in_q, data_in_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              misaligned;
  logic              addr_hi_unused;

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   r = uns ? {24'd0, b} : 32'(b);
      2'b01:   r = uns ? {16'd0, h} : 32'(h);
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00:   r[{lane, 3'b000} +: 8]     = wdata[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Address bits above the DMEM word range wrap and are intentionally dropped.
  assign addr_hi_unused = ^bus.LSU_addr[31:ADDR_W+2];

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = (bus.LSU_size == 2'b01 && bus.LSU_addr[0]) ||
                      (bus.LSU_size[1] && bus.LSU_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    mis_d     = 1'b0;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    data_in_d = data_in_q;
    size_d    = size_q;
    lane_d    = lane_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.LSU_req) begin
          addr_d  = bus.LSU_addr[ADDR_W+1:2];
          size_d  = bus.LSU_size;
          lane_d  = bus.LSU_addr[1:0];
          uns_d   = bus.LSU_unsigned;
          wdata_d = bus.LSU_wdata;
          if (misaligned) begin
            done_d = 1'b1;
            mis_d  = 1'b1;
          end else if (!bus.LSU_we) begin
            state_d = RD;
          end else if (bus.LSU_size[1]) begin
            state_d   = WR;
            data_in_d = bus.LSU_wdata;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      RD:       state_d = RD_WAIT;
      RD_WAIT: begin
        rdata_d = load_extract(bus.DMEM_data_out, size_q, lane_q, uns_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      RMW_RD:   state_d = RMW_WAIT;
      RMW_WAIT: begin
        data_in_d = store_merge(bus.DMEM_data_out, wdata_q, size_q, lane_q);
        state_d   = RMW_WR;
      end
      RMW_WR, WR: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Control and visible output registers
  always_ff @(posedge LSU_clk) begin
    if (LSU_rst) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      data_in_q <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      mis_q     <= mis_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      data_in_q <= data_in_d;
    end
  end

  // Latched request fields, only meaningful while an access is in flight
  always_ff @(posedge LSU_clk) begin
    size_q  <= size_d;
    lane_q  <= lane_d;
    uns_q   <= uns_d;
    wdata_q <= wdata_d;
  end

  assign bus.LSU_busy       = (state_q != IDLE);
  assign bus.LSU_done       = done_q;
  assign bus.LSU_misaligned = mis_q;
  assign bus.LSU_rdata      = rdata_q;
  assign bus.DMEM_address   = addr_q;
  assign bus.DMEM_data_in   = data_in_q;
  assign bus.DMEM_mem_read  = (state_q == RD) || (state_q == RMW_RD);
  assign bus.DMEM_mem_write = (state_q == WR) || (state_q == RMW_WR);

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu against a behavioural DMEM with 1-cycle registered read.
module tb_dmem_lsu;
  localparam int ADDR_W = 8;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   both_cnt = 0;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  int          done_cyc, rd_cyc, wr_cyc;
  logic [31:0] wr_data, addr_seen, rdata_seen;
  logic        mis_seen, busy1;

  dmem_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_lsu #(.ADDR_W(ADDR_W)) dut (
    .LSU_clk (clk),
    .LSU_rst (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (bus.DMEM_mem_write) mem[bus.DMEM_address] <= bus.DMEM_data_in;
    if (bus.DMEM_mem_read)  bus.DMEM_data_out <= mem[bus.DMEM_address];
    if (!rst && bus.DMEM_mem_read && bus.DMEM_mem_write) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and record strobe/done timing relative to the acceptance edge.
  task automatic txn(input logic we, input logic [1:0] sz, input logic un,
                     input logic [31:0] a, input logic [31:0] wd);
    bus.LSU_req = 1'b1; bus.LSU_we = we; bus.LSU_size = sz;
    bus.LSU_unsigned = un; bus.LSU_addr = a; bus.LSU_wdata = wd;
    step();
    bus.LSU_req = 1'b0;
    done_cyc = 0; rd_cyc = 0; wr_cyc = 0; wr_data = 'x;
    mis_seen = 1'bx; rdata_seen = 'x;
    for (int k = 1; k <= 8 && done_cyc == 0; k++) begin
      if (k == 1) begin
        addr_seen = 32'(bus.DMEM_address);
        busy1     = bus.LSU_busy;
      end
      if (bus.DMEM_mem_read && rd_cyc == 0) rd_cyc = k;
      if (bus.DMEM_mem_write) begin
        wr_cyc  = k;
        wr_data = bus.DMEM_data_in;
      end
      if (bus.LSU_done) begin
        done_cyc   = k;
        mis_seen   = bus.LSU_misaligned;
        rdata_seen = bus.LSU_rdata;
      end else begin
        step();
      end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    bus.LSU_req = 1'b0; bus.LSU_we = 1'b0; bus.LSU_size = 2'b00;
    bus.LSU_unsigned = 1'b0; bus.LSU_addr = '0; bus.LSU_wdata = '0;

    // Reset for two cycles
    rst = 1'b1;
    step();
    step();
    check("rst_busy", 32'(bus.LSU_busy), 0);
    check("rst_done", 32'(bus.LSU_done), 0);
    check("rst_mis", 32'(bus.LSU_misaligned), 0);
    check("rst_rdata", bus.LSU_rdata, 0);
    check("rst_addr", 32'(bus.DMEM_address), 0);
    check("rst_din", bus.DMEM_data_in, 0);
    check("rst_strobes", {30'd0, bus.DMEM_mem_read, bus.DMEM_mem_write}, 0);
    rst = 1'b0;
    step();
    check("idle_strobes", {30'd0, bus.DMEM_mem_read, bus.DMEM_mem_write}, 0);

    // Word store then word load
    txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_addr", addr_seen, 32'h04);
    check("sw_busy1", 32'(busy1), 1);
    check("sw_wr_cyc", wr_cyc, 1);
    check("sw_rd_cyc", rd_cyc, 0);
    check("sw_wdata", wr_data, 32'hDEADBEEF);
    check("sw_done_cyc", done_cyc, 2);
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_rd_cyc", rd_cyc, 1);
    check("lw_wr_cyc", wr_cyc, 0);
    check("lw_done_cyc", done_cyc, 3);
    check("lw_rdata", rdata_seen, 32'hDEADBEEF);

    // Sub-word loads with extension
    txn(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    check("lb_s_13", rdata_seen, 32'hFFFFFFDE);
    txn(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    check("lbu_13", rdata_seen, 32'h000000DE);
    txn(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    check("lh_s_10", rdata_seen, 32'hFFFFBEEF);
    txn(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    check("lhu_12", rdata_seen, 32'h0000DEAD);
    check("lhu_done_cyc", done_cyc, 3);

    // Byte store via read-modify-write; rdata must hold the last load
    txn(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA55);
    check("sb_rd_cyc", rd_cyc, 1);
    check("sb_wr_cyc", wr_cyc, 3);
    check("sb_wdata", wr_data, 32'hDEAD55EF);
    check("sb_done_cyc", done_cyc, 4);
    check("sb_rdata_hold", rdata_seen, 32'h0000DEAD);
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_after_sb", rdata_seen, 32'hDEAD55EF);

    // Half store to upper lane, then signed half load
    txn(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF8001);
    check("sh_wdata", wr_data, 32'h800155EF);
    check("sh_done_cyc", done_cyc, 4);
    txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    check("lh_s_12", rdata_seen, 32'hFFFF8001);

    // Misaligned word load
    txn(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("mis_done_cyc", done_cyc, 1);
    check("mis_flag", 32'(mis_seen), 1);
    check("mis_rd_cyc", rd_cyc, 0);
    check("mis_rdata", rdata_seen, 32'hFFFF8001);
`else
    check("mis_done_cyc", done_cyc, 3);
    check("mis_flag", 32'(mis_seen), 0);
    check("mis_addr", addr_seen, 32'h04);
    check("mis_rdata", rdata_seen, 32'h800155EF);
`endif

    // Request held through busy is not re-accepted
    bus.LSU_req = 1'b1; bus.LSU_we = 1'b0; bus.LSU_size = 2'b10;
    bus.LSU_unsigned = 1'b0; bus.LSU_addr = 32'h10;
    step();
    check("hold_c1", {29'd0, bus.LSU_busy, bus.DMEM_mem_read, bus.LSU_done}, 32'b110);
    step();
    check("hold_c2", {29'd0, bus.LSU_busy, bus.DMEM_mem_read, bus.LSU_done}, 32'b100);
    step();
    check("hold_c3", {29'd0, bus.LSU_busy, bus.DMEM_mem_read, bus.LSU_done}, 32'b001);
    bus.LSU_req = 1'b0;
    step();
    check("hold_c4", {29'd0, bus.LSU_busy, bus.DMEM_mem_read, bus.LSU_done}, 32'b000);

    // Reset during RMW_WAIT suppresses the write and the done pulse
    bus.LSU_req = 1'b1; bus.LSU_we = 1'b1; bus.LSU_size = 2'b00;
    bus.LSU_addr = 32'h10; bus.LSU_wdata = 32'h77;
    step();
    bus.LSU_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_c3", {29'd0, bus.LSU_busy, bus.DMEM_mem_write, bus.LSU_done}, 32'b000);
    step();
    check("rstmid_c4", {29'd0, bus.LSU_busy, bus.DMEM_mem_write, bus.LSU_done}, 32'b000);
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("rstmid_mem", rdata_seen, 32'h800155EF);

    // Word address wraps modulo 2^ADDR_W
    txn(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
    check("wrap_3fc", addr_seen, 32'hFF);
    txn(1'b1, 2'b10, 1'b0, 32'h400, 32'h0BADF00D);
    check("wrap_400", addr_seen, 32'h00);
    txn(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    check("wrap_rd0", rdata_seen, 32'h0BADF00D);

    step();
    check("no_rd_wr_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
